// File: rtl/varredura_display.sv
// -----------------------------------------------------------------------------
// varredura_display
//
// Time-multiplexed scan driver for an N-digit common-anode 7-segment display.
// It feeds the downstream segment decoder with one nibble plus dp at a time
// and drives the active-low anode enables. The displayed value is
// double-buffered: loads land in a pending set and move to the active set only
// on a frame boundary, so a frame never mixes old and new digits. Each digit
// slot starts with a dead-time gap (all anodes off) to suppress ghosting.
//
// Parameters:
//   N_DIGITOS    number of digits (>= 2)
//   DIV_REFRESH  clock cycles per digit slot (>= 2)
//   T_MORTO      dead-time cycles at the start of each slot (1..DIV_REFRESH-1)
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   valor          value to show, digit i = valor[4i+3:4i], digit 0 first
//   pontos         per-digit dp, active-low
//   habilita       per-digit enable (1 = shown, 0 = blanked)
//   carregar       capture valor/pontos/habilita at this edge
//   digito         nibble to the decoder
//   dp_out         dp to the decoder, active-low
//   anodos         anode enables, active-low, at most one bit low
//   inicio_quadro  one-cycle pulse on the first cycle of each frame
// -----------------------------------------------------------------------------
module varredura_display #(
  parameter int unsigned N_DIGITOS   = 4,
  parameter int unsigned DIV_REFRESH = 50000,
  parameter int unsigned T_MORTO     = 500
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4*N_DIGITOS-1:0]   valor,
  input  logic [N_DIGITOS-1:0]     pontos,
  input  logic [N_DIGITOS-1:0]     habilita,
  input  logic                     carregar,
  output logic [3:0]               digito,
  output logic                     dp_out,
  output logic [N_DIGITOS-1:0]     anodos,
  output logic                     inicio_quadro
);

  localparam int unsigned CW = $clog2(DIV_REFRESH);
  localparam int unsigned IW = $clog2(N_DIGITOS);

  localparam logic [CW-1:0]        CntMax   = CW'(DIV_REFRESH - 1);
  localparam logic [CW-1:0]        CntMorto = CW'(T_MORTO);
  localparam logic [IW-1:0]        IdxMax   = IW'(N_DIGITOS - 1);
  localparam logic [N_DIGITOS-1:0] UmHot    = N_DIGITOS'(1);

  typedef enum logic [0:0] {
    StApagado,
    StAtivo
  } estado_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]          contador_q, contador_d;
  logic [IW-1:0]          indice_q, indice_d;
  // Set by reset; the first released edge restarts the scan at count 0 of
  // slot 0 so that the first running cycle is a frame start.
  logic                   partida_q;

  logic [4*N_DIGITOS-1:0] valor_p_q, valor_p_d;
  logic [N_DIGITOS-1:0]   pontos_p_q, pontos_p_d;
  logic [N_DIGITOS-1:0]   hab_p_q, hab_p_d;
  logic                   pendente_q, pendente_d;

  logic [4*N_DIGITOS-1:0] valor_a_q, valor_a_d;
  logic [N_DIGITOS-1:0]   pontos_a_q, pontos_a_d;
  logic [N_DIGITOS-1:0]   hab_a_q, hab_a_d;

  estado_e                estado_q, estado_d;

  logic [3:0]             digito_q, digito_d;
  logic                   dp_q, dp_d;
  logic [N_DIGITOS-1:0]   anodos_q, anodos_d;
  logic                   inicio_q, inicio_d;

  logic                   fim_slot;
  logic                   fim_quadro;

  assign fim_slot   = (contador_q == CntMax);
  assign fim_quadro = fim_slot && (indice_q == IdxMax) && !partida_q;

  // ---------------------------------------------------------------------------
  // Prescaler and slot index
  // ---------------------------------------------------------------------------
  always_comb begin
    contador_d = contador_q + 1'b1;
    indice_d   = indice_q;
    if (partida_q) begin
      contador_d = '0;
      indice_d   = '0;
    end else if (fim_slot) begin
      contador_d = '0;
      indice_d   = (indice_q == IdxMax) ? '0 : indice_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending set: last load in a frame wins
  // ---------------------------------------------------------------------------
  always_comb begin
    valor_p_d  = valor_p_q;
    pontos_p_d = pontos_p_q;
    hab_p_d    = hab_p_q;
    pendente_d = pendente_q;
    if (carregar) begin
      valor_p_d  = valor;
      pontos_p_d = pontos;
      hab_p_d    = habilita;
      pendente_d = 1'b1;
    end
    // The boundary consumes whatever is pending, including a same-cycle load
    // that goes straight to the active set.
    if (fim_quadro) begin
      pendente_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Active set: only changes on the frame boundary
  // ---------------------------------------------------------------------------
  always_comb begin
    valor_a_d  = valor_a_q;
    pontos_a_d = pontos_a_q;
    hab_a_d    = hab_a_q;
    if (fim_quadro) begin
      if (carregar) begin
        valor_a_d  = valor;
        pontos_a_d = pontos;
        hab_a_d    = habilita;
      end else if (pendente_q) begin
        valor_a_d  = valor_p_q;
        pontos_a_d = pontos_p_q;
        hab_a_d    = hab_p_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      contador_q <= '0;
      indice_q   <= '0;
      partida_q  <= 1'b1;
      valor_p_q  <= '0;
      pontos_p_q <= '1;
      hab_p_q    <= '1;
      pendente_q <= 1'b0;
      valor_a_q  <= '0;
      pontos_a_q <= '1;
      hab_a_q    <= '1;
    end else begin
      contador_q <= contador_d;
      indice_q   <= indice_d;
      partida_q  <= 1'b0;
      valor_p_q  <= valor_p_d;
      pontos_p_q <= pontos_p_d;
      hab_p_q    <= hab_p_d;
      pendente_q <= pendente_d;
      valor_a_q  <= valor_a_d;
      pontos_a_q <= pontos_a_d;
      hab_a_q    <= hab_a_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= StApagado;
    end else begin
      estado_q <= estado_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot FSM: next state, evaluated on the lookahead count so the state always
  // matches the counter value it is registered alongside.
  // ---------------------------------------------------------------------------
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      StApagado: begin
        if (contador_d == CntMorto) begin
          estado_d = StAtivo;
        end
      end
      StAtivo: begin
        if (contador_d == '0) begin
          estado_d = StApagado;
        end
      end
      default: estado_d = StApagado;
    endcase
    if (partida_q) begin
      estado_d = StApagado;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot FSM: outputs, computed from next-state values and registered, so the
  // pins carry zero lag relative to the counters. The decoder is fed for the
  // whole slot, dead time included, so it has settled before the anode opens.
  // ---------------------------------------------------------------------------
  always_comb begin
    digito_d = valor_a_d[{indice_d, 2'b00} +: 4];
    dp_d     = pontos_a_d[indice_d];
    anodos_d = '1;
    if ((estado_d == StAtivo) && hab_a_d[indice_d]) begin
      anodos_d = ~(UmHot << indice_d);
    end
    inicio_d = (contador_d == '0) && (indice_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digito_q <= 4'h0;
      dp_q     <= 1'b1;
      anodos_q <= '1;
      inicio_q <= 1'b0;
    end else begin
      digito_q <= digito_d;
      dp_q     <= dp_d;
      anodos_q <= anodos_d;
      inicio_q <= inicio_d;
    end
  end

  assign digito        = digito_q;
  assign dp_out        = dp_q;
  assign anodos        = anodos_q;
  assign inicio_quadro = inicio_q;

endmodule

// File: doc/varredura_display.md
# varredura_display

Time-multiplexed scan driver for an N-digit, common-anode 7-segment display. It sits directly upstream of the per-digit 7-segment decoder. The decoder maps a 4-bit code plus a dp bit to active-low segments `{dp, abcdefg}`. This block double-buffers the displayed value, steps through the digits at a fixed refresh rate, drives the selected digit's nibble and dp to the decoder, and drives the active-low anode enables with a dead-time gap between digits to suppress ghosting.

## Interface
- `N_DIGITOS`, 4: number of digits; must be ≥ 2.
- `DIV_REFRESH`, 50000: clock cycles per digit slot; must be ≥ 2.
- `T_MORTO`, 500: dead-time cycles at the start of each slot, during which all anodes are off; 1 ≤ `T_MORTO` < `DIV_REFRESH`.

- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `valor` in 4*N_DIGITOS: hex value to display; digit i is `valor[4i+3:4i]`, and digit 0 is scanned first.
- `pontos` in N_DIGITOS: per-digit dp, active-low (0 = lit).
- `habilita` in N_DIGITOS: per-digit enable, 1 = shown, 0 = blanked.
- `carregar` in 1: when high at a clock edge, `valor`/`pontos`/`habilita` are captured.
- `digito` out 4: nibble to the decoder input.
- `dp_out` out 1: dp to the decoder dp input, active-low.
- `anodos` out N_DIGITOS: anode enables, active-low, at most one bit low.
- `inicio_quadro` out 1: one-cycle pulse on the first cycle of each frame.

## Operation
- **Registers.**
  - Prescaler `contador` has width `$clog2(DIV_REFRESH)` and counts 0..DIV_REFRESH-1.
  - Slot index `indice` counts 0..N_DIGITOS-1.
  - Pending set: `valor_p`, `pontos_p`, `hab_p`, and flag `pendente`.
  - Active set: `valor_a`, `pontos_a`, `hab_a`.
- **Counting.** `contador` increments every cycle. At `DIV_REFRESH-1` it wraps to 0 and `indice` advances. `indice` wraps from N_DIGITOS-1 to 0; that wrap is the frame boundary.
- **Capture.**
  - `carregar`=1 writes the inputs into the pending set and sets `pendente`.
  - Repeated loads within one frame overwrite the pending set; the last load wins.
  - The pending set never drives outputs directly.
- **Frame boundary** (cycle with `contador`=DIV_REFRESH-1 and `indice`=N_DIGITOS-1):
  - If `carregar`=1 in that same cycle, the active set is loaded directly from the inputs.
  - Otherwise, if `pendente`=1, the active set is loaded from the pending set.
  - `pendente` clears in both cases.
  - The new value is first shown at digit 0 of the next frame. A frame never mixes old and new digits.
- **Two-state slot FSM.**
  - APAGADO: `contador` < T_MORTO. `anodos` is all 1s.
  - ATIVO: `contador` ≥ T_MORTO. `anodos[indice]`=0 if `hab_a[indice]`=1, otherwise all 1s.
  - APAGADO→ATIVO when `contador` reaches T_MORTO. ATIVO→APAGADO on the slot wrap.
- **Decoder feed.**
  - `digito` = `valor_a[4*indice+3 : 4*indice]` and `dp_out` = `pontos_a[indice]` for the whole slot, including dead time, so the decoder settles before the anode turns on.
  - A blanked digit still drives `digito` and `dp_out`.
- **Reset** (rst_n=0 at an edge, including mid-frame):
  - `contador`=0, `indice`=0, state APAGADO.
  - Active and pending `valor` = 0, `pontos` = all 1s, `habilita` = all 1s, `pendente`=0. Any pending load is discarded.
  - Outputs: `anodos` all 1s, `digito`=0, `dp_out`=1, `inicio_quadro`=0.

## Timing
- All outputs are registered and glitch-free. Their values in a cycle are a function of that cycle's `contador`/`indice` and the active set, implemented with next-state lookahead, so there is zero cycle lag relative to the counters.
- Anode i is low exactly for `contador` ∈ [T_MORTO, DIV_REFRESH-1] of slot i, i.e. DIV_REFRESH−T_MORTO cycles per frame.
- A frame lasts N_DIGITOS·DIV_REFRESH cycles.
- `inicio_quadro`=1 in every cycle with `contador`=0 and `indice`=0 and `rst_n`=1. This includes the first cycle after reset release.
- Load latency: a value applied at any point in frame k is first displayed at the start of frame k+1. This holds for a load on the boundary cycle of frame k as well.
- `pendente` is internal only; there is no backpressure, and `carregar` is accepted every cycle.

## Test plan
All scenarios use N_DIGITOS=4, DIV_REFRESH=8, T_MORTO=2.
- **Reset:** hold rst_n=0 for 3 cycles → `anodos`=4'b1111, `digito`=0, `dp_out`=1, `inicio_quadro`=0. Release → `inicio_quadro`=1 on the first cycle; `anodos`=4'b1110 during cycles 2–7.
- **Load and scan:** pulse `carregar` once with `valor`=16'h1A3F, `pontos`=4'b1110, `habilita`=4'hF. In the next frame:
  - slot 0: `digito`=F, `dp_out`=0, `anodos`=1111 for counts 0–1, then 1110 for counts 2–7;
  - slots 1–3: `digito`=3/A/1, `dp_out`=1, `anodos`=1101/1011/0111.
- **Mid-frame load:** with 16'h1A3F shown, pulse `carregar` with 16'h0000 during slot 1 → slots 2–3 still show A and 1; the next frame shows 0 on all digits.
- **Blanking:** `habilita`=4'b1011 → `anodos` stays 1111 for all of slot 2 while `digito` still equals nibble 2; the other slots are unaffected.
- **Boundary and overwrite:** `carregar` with 16'h5555 on the boundary cycle → digit 0 of the new frame shows 5. Two loads in one frame (16'h1111, then 16'h2222) → the next frame shows 2222.
- **Reset mid-operation:** drop rst_n in slot 2 with a load pending → the next edge gives reset values; after release, digit 0 shows 0 and the pending value never appears.
